// File: rtl/pad_window_fetcher_pkg.sv
// rtl/pad_window_fetcher_pkg.sv - shared geometry constants and FSM state type for the padded window fetcher
package pad_window_fetcher_pkg;
    localparam int IMG_W = 64;
    localparam int PAD_W = IMG_W + 2;
    localparam int DW    = 20;
    localparam int AW    = 13;
    localparam int HOLD  = 2;
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_t;
endpackage

// File: rtl/pad_window_fetcher_window_shift_reg.sv
// rtl/pad_window_fetcher_window_shift_reg.sv - 3x3 tap store; loads into column 2, shifts columns left
module window_shift_reg
    import pad_window_fetcher_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [1:0]      load_dr,
    input  logic            shift,
    input  logic [DW-1:0]   din,
    output logic [9*DW-1:0] win_flat
);
    logic [DW-1:0] taps [3][3];   // taps[dc][dr]

    // shift and load may coincide: the shift reads the old column 2 before it is overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    taps[i][j] <= '0;
        end else begin
            if (shift) begin
                for (int j = 0; j < 3; j++) begin
                    taps[0][j] <= taps[1][j];
                    taps[1][j] <= taps[2][j];
                end
            end
            if (load)
                taps[2][load_dr] <= din;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                win_flat[DW*(3*dr+dc) +: DW] = taps[dc][dr];
    end
endmodule

// File: rtl/pad_window_fetcher.sv
// rtl/pad_window_fetcher.sv - raster-scans the padded image and emits one 3x3 window per centre
module pad_window_fetcher
    import pad_window_fetcher_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   pseudo_addr,
    input  logic [DW-1:0]   data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_flat,
    output logic [5:0]      win_row,
    output logic [5:0]      win_col
);
    state_t        state, next_state;
    logic [5:0]    row, col;
    logic [AW-1:0] row_base;
    logic [1:0]    tap_dr, tap_dc;
    logic [HW-1:0] hold_cnt;
    logic          addr_pending;
    logic          capture, accept, last_tap, last_win;

    assign last_tap  = (tap_dr == 2'd2) && (tap_dc == 2'd2);
    assign last_win  = (row == 6'(IMG_W-1)) && (col == 6'(IMG_W-1));
    assign busy      = (state == FETCH) || (state == EMIT);
    assign done      = (state == DONE);
    assign win_valid = (state == EMIT);
    assign win_row   = row;
    assign win_col   = col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: if (!addr_pending && hold_cnt == HW'(HOLD-1)) begin
                capture = 1'b1;
                if (last_tap) next_state = EMIT;
            end
            EMIT:  if (win_ready) begin
                accept     = 1'b1;
                next_state = last_win ? DONE : FETCH;
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // After an accept one cycle is spent forming the new column's base address from row_base.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row          <= '0;
            col          <= '0;
            row_base     <= '0;
            pseudo_addr  <= '0;
            tap_dr       <= '0;
            tap_dc       <= '0;
            hold_cnt     <= '0;
            addr_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    row          <= '0;
                    col          <= '0;
                    row_base     <= '0;
                    pseudo_addr  <= '0;
                    tap_dr       <= '0;
                    tap_dc       <= '0;
                    hold_cnt     <= '0;
                    addr_pending <= 1'b0;
                end
                FETCH: begin
                    if (addr_pending) begin
                        addr_pending <= 1'b0;
                        pseudo_addr  <= row_base + AW'(col) + ((col == '0) ? AW'(0) : AW'(2));
                    end else if (capture) begin
                        hold_cnt <= '0;
                        if (tap_dr == 2'd2) begin
                            if (!last_tap) begin
                                tap_dr      <= '0;
                                tap_dc      <= tap_dc + 2'd1;
                                pseudo_addr <= pseudo_addr - AW'(2*PAD_W - 1);
                            end
                        end else begin
                            tap_dr      <= tap_dr + 2'd1;
                            pseudo_addr <= pseudo_addr + AW'(PAD_W);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                EMIT: if (accept) begin
                    if (col == 6'(IMG_W-1)) begin
                        col      <= '0;
                        row      <= row + 6'd1;
                        row_base <= row_base + AW'(PAD_W);
                        tap_dc   <= 2'd0;
                    end else begin
                        col    <= col + 6'd1;
                        tap_dc <= 2'd2;
                    end
                    tap_dr       <= '0;
                    hold_cnt     <= '0;
                    addr_pending <= 1'b1;
                end
                DONE: pseudo_addr <= '0;
                default: ;
            endcase
        end
    end

    window_shift_reg u_win (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .load_dr  (tap_dr),
        .shift    (capture && (tap_dr == 2'd0) && (tap_dc != 2'd0)),
        .din      (data),
        .win_flat (win_flat)
    );
endmodule

// File: tb/tb_pad_window_fetcher.sv
// tb/tb_pad_window_fetcher.sv - randomized self-checking bench against a padded-image reference model
module tb_pad_window_fetcher;
    localparam int DW = 20;
    localparam int AW = 13;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            busy, done;
    logic [AW-1:0]   pseudo_addr;
    logic [DW-1:0]   data;
    logic            win_valid;
    logic            win_ready = 1'b0;
    logic [9*DW-1:0] win_flat;
    logic [5:0]      win_row, win_col;

    int checks = 0;
    int errors = 0;
    bit stuck  = 0;

    pad_window_fetcher dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pseudo_addr (pseudo_addr),
        .data        (data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_flat    (win_flat),
        .win_row     (win_row),
        .win_col     (win_col)
    );

    always #5 clk = ~clk;

    function automatic int pix(input int rr, input int cc);
        if (rr < 0 || rr > 63 || cc < 0 || cc > 63) return 0;
        return rr * 64 + cc + 1;
    endfunction

    function automatic logic [DW-1:0] responder(input logic [AW-1:0] pa);
        int p;
        p = int'(pa);
        return DW'(pix(p / 66 - 1, p % 66 - 1));
    endfunction

    always_comb data = responder(pseudo_addr);

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[DW*(3*dr+dc) +: DW] = DW'(pix(r + dr - 1, c + dc - 1));
        return w;
    endfunction

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic run_window(input int r, input int c, input bit after_start,
                              input int stall, input bit poke_start);
        int q[$];
        int n, ntap, t, dr, dc, idx, got;
        int last_pa;
        n    = 0;
        ntap = (c == 0) ? 9 : 3;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (win_valid) break;
            if (poke_start && n == 2) start = 1'b1;
            win_ready = 1'($urandom_range(0, 1));
            q.push_back(int'(pseudo_addr));
            n++;
            if (n > 64) begin
                check("fetch_timeout", 200'(n), 200'(0));
                stuck = 1;
                return;
            end
        end
        if (after_start)  check("first_latency", 200'(n), 200'(18));
        else if (c > 0)   check("reuse_latency", 200'(n), 200'(7));
        else              check("row_latency", 200'(n >= 18), 200'(1));
        for (int k = 0; k < ntap * 2; k++) begin
            t   = k / 2;
            dc  = (ntap == 9) ? t / 3 : 2;
            dr  = t % 3;
            idx = n - ntap * 2 + k;
            got = (idx >= 0) ? q[idx] : -1;
            check("pa_seq", 200'(got), 200'((r + dr) * 66 + c + dc));
        end
        check("win_flat", 200'(win_flat), 200'(exp_win(r, c)));
        check("win_row", 200'(win_row), 200'(r));
        check("win_col", 200'(win_col), 200'(c));
        check("busy_emit", 200'(busy), 200'(1));
        check("done_emit", 200'(done), 200'(0));
        last_pa = (r + 2) * 66 + c + 2;
        for (int i = 0; i < stall; i++) begin
            win_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", 200'(win_valid), 200'(1));
            check("stall_flat", 200'(win_flat), 200'(exp_win(r, c)));
            check("stall_rc", 200'({win_row, win_col}), 200'({6'(r), 6'(c)}));
            check("stall_pa", 200'(pseudo_addr), 200'(last_pa));
        end
        win_ready = 1'b1;
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        summary_and_finish();
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 200'(busy), 200'(0));
        check("rst_done", 200'(done), 200'(0));
        check("rst_pa", 200'(pseudo_addr), 200'(0));
        check("rst_valid", 200'(win_valid), 200'(0));
        check("rst_out", 200'({win_flat, win_row, win_col}), 200'(0));
        reset = 1'b0;
        @(negedge clk);

        start = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            run_window(i / 64, i % 64, i == 0, (i == 5) ? 10 : (($urandom_range(0, 3) == 0) ? 2 : 0), 1'b0);
            if (stuck) summary_and_finish();
        end
        @(negedge clk);
        win_ready = 1'b0;
        check("done_pulse", 200'(done), 200'(1));
        check("done_busy", 200'(busy), 200'(0));
        check("done_valid", 200'(win_valid), 200'(0));
        @(negedge clk);
        check("done_clear", 200'(done), 200'(0));
        check("idle_busy", 200'(busy), 200'(0));
        check("idle_pa", 200'(pseudo_addr), 200'(0));

        start = 1'b1;
        run_window(0, 0, 1'b1, 0, 1'b0);
        if (stuck) summary_and_finish();
        run_window(0, 1, 1'b0, 0, 1'b1);
        if (stuck) summary_and_finish();
        run_window(0, 2, 1'b0, 1, 1'b0);
        if (stuck) summary_and_finish();
        @(negedge clk);
        win_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 200'(busy), 200'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 200'(busy), 200'(0));
        check("arst_valid", 200'(win_valid), 200'(0));
        check("arst_pa", 200'(pseudo_addr), 200'(0));
        check("arst_out", 200'({win_flat, win_row, win_col, done}), 200'(0));
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        run_window(0, 0, 1'b1, 0, 1'b0);
        if (stuck) summary_and_finish();
        run_window(0, 1, 1'b0, 0, 1'b0);
        if (stuck) summary_and_finish();
        @(negedge clk);
        reset = 1'b1;
        summary_and_finish();
    end
endmodule
